mult_request_master: RTL and testbench

// - Initiator side of the multiplier handshake (iValid_Data / iAcknoledged / oDone / oIdle).
// - Buffers operand pairs from upstream in a small FIFO and issues them one at a time to the Multiplicator.
// - Captures each product into a single-entry result slot with a valid/ready output, and acknowledges the Done.
// - Sits between the control/datapath producer and the Multiplicator instance.

---
 rtl/mult_master_pkg.sv | 14 +
 rtl/operand_fifo.sv | 54 +++++
 rtl/mult_request_master.sv | 132 +++++++++++++
 tb/tb_mult_request_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_master_pkg.sv
// rtl/mult_master_pkg.sv - shared constants for the multiplier request master
package mult_master_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_CNT_W   = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_ACK       = 2'd3;

endpackage

// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - operand-pair FIFO with occupancy count
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module operand_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mult_request_master.sv
// rtl/mult_request_master.sv - queues operand pairs and drives the multiplier handshake
// Products land in a one-entry result slot; a stalled slot holds off the Done acknowledge.
module mult_request_master
  import mult_master_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iPush,
  input  logic [DATA_W-1:0]             iOperand_A,
  input  logic [DATA_W-1:0]             iOperand_B,
  output logic                          oFull,
  output logic [$clog2(FIFO_DEPTH):0]   oPending,
  output logic [DATA_W-1:0]             oData_A,
  output logic [DATA_W-1:0]             oData_B,
  output logic                          oValid_Data,
  output logic                          oAcknowledged,
  input  logic                          iDone,
  input  logic                          iIdle,
  input  logic [DATA_W-1:0]             iResult,
  output logic                          oResult_Valid,
  output logic [DATA_W-1:0]             oResult,
  input  logic                          iResult_Ready,
  output logic                          oTimeout,
  input  logic                          iClear_Timeout,
  output logic [OP_CNT_W-1:0]           oOp_Count
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t              state;
  logic [TW-1:0]       timer;
  logic [2*DATA_W-1:0] head;
  logic                empty;
  logic                pop;
  logic                capture;
  logic                timeout_hit;

  operand_fifo #(
    .WIDTH (2*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (Clock),
    .resetn (Reset),
    .push   (iPush),
    .din    ({iOperand_A, iOperand_B}),
    .pop    (pop),
    .dout   (head),
    .full   (oFull),
    .empty  (empty),
    .count  (oPending)
  );

  // A read of the slot on the same edge frees it for the incoming product.
  always_comb begin
    pop         = (state == ST_IDLE) && !empty && iIdle;
    capture     = (state == ST_WAIT_DONE) && iDone && (!oResult_Valid || iResult_Ready);
    timeout_hit = (((state == ST_ISSUE) && iIdle) || ((state == ST_WAIT_DONE) && !capture))
                  && (timer == TW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      oData_A       <= '0;
      oData_B       <= '0;
      oValid_Data   <= 1'b0;
      oAcknowledged <= 1'b0;
      oResult_Valid <= 1'b0;
      oResult       <= '0;
      oTimeout      <= 1'b0;
      oOp_Count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            oData_A     <= head[2*DATA_W-1:DATA_W];
            oData_B     <= head[DATA_W-1:0];
            oValid_Data <= 1'b1;
            timer       <= '0;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!iIdle) begin
            oValid_Data <= 1'b0;
            timer       <= '0;
            state       <= ST_WAIT_DONE;
          end else if (timeout_hit) begin
            oValid_Data <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (capture) begin
            oAcknowledged <= 1'b1;
            state         <= ST_ACK;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_ACK: begin
          if (!iDone) begin
            oAcknowledged <= 1'b0;
            oOp_Count     <= oOp_Count + 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (capture) begin
        oResult       <= iResult;
        oResult_Valid <= 1'b1;
      end else if (oResult_Valid && iResult_Ready) begin
        oResult_Valid <= 1'b0;
      end

      if (timeout_hit)         oTimeout <= 1'b1;
      else if (iClear_Timeout) oTimeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_request_master.sv
// tb/tb_mult_request_master.sv - scoreboard bench with a behavioural multiplier slave
module tb_mult_request_master;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iPush;
  logic [31:0] iOperand_A, iOperand_B;
  logic        oFull;
  logic [2:0]  oPending;
  logic [31:0] oData_A, oData_B;
  logic        oValid_Data, oAcknowledged;
  logic        iResult_Ready, iClear_Timeout;
  logic        oResult_Valid, oTimeout;
  logic [31:0] oResult;
  logic [15:0] oOp_Count;

  logic        s_idle_r, s_done, busy, stuck, idle_at_edge, v_prev;
  logic [31:0] s_res;
  int          s_cnt, s_st;
  logic        slave_idle;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  assign slave_idle = s_idle_r && !busy;

  always #5 Clock = ~Clock;

  mult_request_master dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .iPush          (iPush),
    .iOperand_A     (iOperand_A),
    .iOperand_B     (iOperand_B),
    .oFull          (oFull),
    .oPending       (oPending),
    .oData_A        (oData_A),
    .oData_B        (oData_B),
    .oValid_Data    (oValid_Data),
    .oAcknowledged  (oAcknowledged),
    .iDone          (s_done),
    .iIdle          (slave_idle),
    .iResult        (s_res),
    .oResult_Valid  (oResult_Valid),
    .oResult        (oResult),
    .iResult_Ready  (iResult_Ready),
    .oTimeout       (oTimeout),
    .iClear_Timeout (iClear_Timeout),
    .oOp_Count      (oOp_Count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Slave: accepts when idle, raises Done 3 cycles later, holds it until acknowledged.
  always @(posedge Clock) begin
    idle_at_edge <= slave_idle;
    if (!Reset) begin
      s_idle_r <= 1'b1;
      s_done   <= 1'b0;
      s_st     <= 0;
      s_cnt    <= 0;
      s_res    <= '0;
    end else begin
      case (s_st)
        0: if (oValid_Data && slave_idle && !stuck) begin
             s_idle_r <= 1'b0;
             s_res    <= oData_A * oData_B;
             s_cnt    <= 0;
             s_st     <= 1;
           end
        1: begin
             if (s_cnt == 2) begin
               s_done <= 1'b1;
               s_st   <= 2;
             end
             s_cnt <= s_cnt + 1;
           end
        default: if (oAcknowledged) begin
             s_done   <= 1'b0;
             s_idle_r <= 1'b1;
             s_st     <= 0;
           end
      endcase
    end
  end

  always @(negedge Clock) begin
    if (Reset) begin
      if (oValid_Data && !v_prev) chk("issue_while_idle", idle_at_edge, 1);
      if (oResult_Valid && iResult_Ready) begin
        chk("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("result", oResult, exp_q.pop_front());
      end
    end
    v_prev <= oValid_Data;
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input bit scored);
    iPush = 1'b1; iOperand_A = a; iOperand_B = b;
    if (scored) exp_q.push_back(a * b);
    step();
    iPush = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; iPush = 1'b0; iOperand_A = '0; iOperand_B = '0;
    iResult_Ready = 1'b1; iClear_Timeout = 1'b0; busy = 1'b0; stuck = 1'b0; v_prev = 1'b0;
    repeat (3) step();
    chk("rst_valid", oValid_Data, 0);
    chk("rst_ack", oAcknowledged, 0);
    chk("rst_pending", oPending, 0);
    chk("rst_full", oFull, 0);
    chk("rst_rvalid", oResult_Valid, 0);
    chk("rst_timeout", oTimeout, 0);
    chk("rst_opcnt", oOp_Count, 0);
    Reset = 1'b1;
    step();

    push(1, 1, 1); push(2, 2, 1); push(3, 3, 1);
    for (int i = 0; i < 300 && oOp_Count != 16'd3; i++) step();
    chk("op_count_3", oOp_Count, 3);

    busy = 1'b1;
    push(5, 6, 1); push(7, 8, 1); push(9, 10, 1); push(11, 12, 1);
    chk("full_after_4", oFull, 1);
    chk("pending_4", oPending, 4);
    push(13, 14, 0);
    chk("pending_after_5th", oPending, 4);
    busy = 1'b0;
    push(15, 16, 1);
    chk("pushpop_pending", oPending, 4);
    chk("pushpop_full", oFull, 1);
    chk("pushpop_issue", oValid_Data, 1);
    for (int i = 0; i < 500 && oOp_Count != 16'd8; i++) step();
    chk("op_count_8", oOp_Count, 8);

    iResult_Ready = 1'b0;
    push(2, 3, 1); push(4, 5, 1);
    for (int i = 0; i < 200 && oOp_Count != 16'd9; i++) step();
    chk("op_count_9", oOp_Count, 9);
    for (int i = 0; i < 200 && !s_done; i++) step();
    repeat (4) step();
    chk("ack_stalled", oAcknowledged, 0);
    chk("slot_held", oResult, 6);
    chk("slot_held_valid", oResult_Valid, 1);
    iResult_Ready = 1'b1;
    step();
    chk("ack_after_read", oAcknowledged, 1);
    chk("slot_new_data", oResult, 20);
    chk("slot_still_valid", oResult_Valid, 1);
    for (int i = 0; i < 200 && oOp_Count != 16'd10; i++) step();
    chk("op_count_10", oOp_Count, 10);

    stuck = 1'b1;
    push(7, 7, 0);
    repeat (30) step();
    chk("to_still_valid", oValid_Data, 1);
    chk("to_not_yet", oTimeout, 0);
    for (int i = 0; i < 100 && !oTimeout; i++) step();
    chk("to_set", oTimeout, 1);
    chk("to_valid_drop", oValid_Data, 0);
    chk("to_pending", oPending, 0);
    chk("to_opcnt", oOp_Count, 10);
    iClear_Timeout = 1'b1;
    step();
    iClear_Timeout = 1'b0;
    chk("to_cleared", oTimeout, 0);
    stuck = 1'b0;

    iResult_Ready = 1'b0;
    push(3, 4, 0); push(5, 6, 0); push(1, 2, 0);
    for (int i = 0; i < 200 && !oAcknowledged; i++) step();
    chk("ack_before_reset", oAcknowledged, 1);
    Reset = 1'b0;
    step();
    chk("mrst_valid", oValid_Data, 0);
    chk("mrst_ack", oAcknowledged, 0);
    chk("mrst_pending", oPending, 0);
    chk("mrst_full", oFull, 0);
    chk("mrst_rvalid", oResult_Valid, 0);
    chk("mrst_result", oResult, 0);
    chk("mrst_data_a", oData_A, 0);
    chk("mrst_opcnt", oOp_Count, 0);
    Reset = 1'b1;
    iResult_Ready = 1'b1;
    repeat (3) step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
